// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control bundle layout, ALUOp encodings and
// register-index constants used by the ID/EX stage and its hazard logic.
package pipe_pkg;

    localparam int CTRL_W  = 9;
    localparam int REG_W   = 5;
    localparam int FUNCT_W = 10;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // ALUOp encodings carried in the control bundle.
    localparam logic [1:0] ALUOP_LDST = 2'b00;
    localparam logic [1:0] ALUOP_BR   = 2'b01;
    localparam logic [1:0] ALUOP_R    = 2'b10;
    localparam logic [1:0] ALUOP_I    = 2'b11;

    // Decoded control bundle, MSB first.
    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memread;
        logic       memwrite;
        logic       alusrc;
        logic [1:0] aluop;
        logic       branch;
        logic       spare;
    } ctrl_t;

    // A bubble carries no side effects: no write, no memory access, no branch.
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: the instruction in EX is a valid load whose
// destination (non-zero) is a source of the valid instruction in ID.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic             ex_valid_i,
    input  logic             ex_memread_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    output logic             haz_o
);

    // Combinational hazard term; x0 never creates a dependency.
    always_comb begin
        haz_o = ex_memread_i & ex_valid_i & (ex_rd_i != REG_ZERO) &
                ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i)) & id_valid_i;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Loads decoded ID state into EX each cycle, inserts
// a bubble on branch flush or load-use hazard, freezes on a global hold, and
// counts inserted bubbles with saturating counters.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               hold_i,
    input  logic               flush_i,
    input  logic               id_valid_i,
    input  logic [XLEN-1:0]    id_pc_i,
    input  logic [XLEN-1:0]    id_rs1_data_i,
    input  logic [XLEN-1:0]    id_rs2_data_i,
    input  logic [XLEN-1:0]    id_imm_i,
    input  logic [4:0]         id_rs1_i,
    input  logic [4:0]         id_rs2_i,
    input  logic [4:0]         id_rd_i,
    input  logic [8:0]         id_ctrl_i,
    input  logic [9:0]         id_funct_i,
    output logic               ex_valid_o,
    output logic [XLEN-1:0]    ex_pc_o,
    output logic [XLEN-1:0]    ex_rs1_data_o,
    output logic [XLEN-1:0]    ex_rs2_data_o,
    output logic [XLEN-1:0]    ex_imm_o,
    output logic [4:0]         ex_rs1_o,
    output logic [4:0]         ex_rs2_o,
    output logic [4:0]         ex_rd_o,
    output logic [8:0]         ex_ctrl_o,
    output logic [9:0]         ex_funct_o,
    output logic               stall_o,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   flush_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic               valid_q,     valid_d;
    logic [XLEN-1:0]    pc_q,        pc_d;
    logic [XLEN-1:0]    rs1_data_q,  rs1_data_d;
    logic [XLEN-1:0]    rs2_data_q,  rs2_data_d;
    logic [XLEN-1:0]    imm_q,       imm_d;
    logic [REG_W-1:0]   rs1_q,       rs1_d;
    logic [REG_W-1:0]   rs2_q,       rs2_d;
    logic [REG_W-1:0]   rd_q,        rd_d;
    ctrl_t              ctrl_q,      ctrl_d;
    logic [FUNCT_W-1:0] funct_q,     funct_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic haz;

    hazard_detect u_hazard_detect (
        .ex_valid_i   (valid_q),
        .ex_memread_i (ctrl_q.memread),
        .ex_rd_i      (rd_q),
        .id_valid_i   (id_valid_i),
        .id_rs1_i     (id_rs1_i),
        .id_rs2_i     (id_rs2_i),
        .haz_o        (haz)
    );

    // Stall request to PC and IF/ID: a flush or a hold overrides the hazard.
    always_comb begin
        stall_o = haz & ~flush_i & ~hold_i;
    end

    // Next-state selection in priority order: hold, flush, hazard, load.
    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        ctrl_d      = ctrl_q;
        funct_d     = funct_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (!hold_i) begin
            // Datapath fields follow ID on both loads and bubbles.
            pc_d       = id_pc_i;
            rs1_data_d = id_rs1_data_i;
            rs2_data_d = id_rs2_data_i;
            imm_d      = id_imm_i;
            rs1_d      = id_rs1_i;
            rs2_d      = id_rs2_i;
            funct_d    = id_funct_i;

            if (flush_i || haz) begin
                // Bubble: nothing that can write, forward or raise a hazard.
                valid_d = 1'b0;
                ctrl_d  = CTRL_BUBBLE;
                rd_d    = REG_ZERO;
                if (flush_i) begin
                    flush_cnt_d = (flush_cnt_q == CNT_MAX) ? flush_cnt_q
                                                           : flush_cnt_q + CNT_W'(1);
                end else begin
                    stall_cnt_d = (stall_cnt_q == CNT_MAX) ? stall_cnt_q
                                                           : stall_cnt_q + CNT_W'(1);
                end
            end else begin
                valid_d = id_valid_i;
                ctrl_d  = ctrl_t'(id_ctrl_i);
                rd_d    = id_rd_i;
            end
        end
    end

    // Stage registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst_i) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            ctrl_q      <= CTRL_BUBBLE;
            funct_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            ctrl_q      <= ctrl_d;
            funct_q     <= funct_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid_o    = valid_q;
    assign ex_pc_o       = pc_q;
    assign ex_rs1_data_o = rs1_data_q;
    assign ex_rs2_data_o = rs2_data_q;
    assign ex_imm_o      = imm_q;
    assign ex_rs1_o      = rs1_q;
    assign ex_rs2_o      = rs2_q;
    assign ex_rd_o       = rd_q;
    assign ex_ctrl_o     = ctrl_q;
    assign ex_funct_o    = funct_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a directed vector table, asynchronous
// reset and counter saturation sequences, and randomized traffic checked
// against a behavioural model. A second instance with 4-bit counters shares
// all inputs.
module tb_id_ex_stage;

    localparam int XLEN = 32;

    // Control bundles {regwrite,memtoreg,memread,memwrite,alusrc,aluop,branch,spare}
    localparam bit [8:0] C_LW   = 9'b1_1_1_0_1_00_0_0;
    localparam bit [8:0] C_ADD  = 9'b1_0_0_0_0_10_0_0;
    localparam bit [8:0] C_ADDI = 9'b1_0_0_0_1_11_0_0;
    localparam bit [8:0] C_SW   = 9'b0_0_0_1_1_00_0_0;
    localparam int MEMREAD_BIT = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic hold = 1'b0, flush = 1'b0, id_valid = 1'b0;
    logic [XLEN-1:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [8:0] id_ctrl = '0;
    logic [9:0] id_funct = '0;

    logic            ex_valid, stall;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic [8:0]      ex_ctrl;
    logic [9:0]      ex_funct;
    logic [31:0]     stall_cnt, flush_cnt;

    logic            d4_valid, d4_stall;
    logic [XLEN-1:0] d4_pc, d4_rs1_data, d4_rs2_data, d4_imm;
    logic [4:0]      d4_rs1, d4_rs2, d4_rd;
    logic [8:0]      d4_ctrl;
    logic [9:0]      d4_funct;
    logic [3:0]      d4_stall_cnt, d4_flush_cnt;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(32)) u_dut (
        .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush),
        .id_valid_i(id_valid), .id_pc_i(id_pc), .id_rs1_data_i(id_rs1_data),
        .id_rs2_data_i(id_rs2_data), .id_imm_i(id_imm), .id_rs1_i(id_rs1),
        .id_rs2_i(id_rs2), .id_rd_i(id_rd), .id_ctrl_i(id_ctrl), .id_funct_i(id_funct),
        .ex_valid_o(ex_valid), .ex_pc_o(ex_pc), .ex_rs1_data_o(ex_rs1_data),
        .ex_rs2_data_o(ex_rs2_data), .ex_imm_o(ex_imm), .ex_rs1_o(ex_rs1),
        .ex_rs2_o(ex_rs2), .ex_rd_o(ex_rd), .ex_ctrl_o(ex_ctrl), .ex_funct_o(ex_funct),
        .stall_o(stall), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    id_ex_stage #(.XLEN(XLEN), .CNT_W(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush),
        .id_valid_i(id_valid), .id_pc_i(id_pc), .id_rs1_data_i(id_rs1_data),
        .id_rs2_data_i(id_rs2_data), .id_imm_i(id_imm), .id_rs1_i(id_rs1),
        .id_rs2_i(id_rs2), .id_rd_i(id_rd), .id_ctrl_i(id_ctrl), .id_funct_i(id_funct),
        .ex_valid_o(d4_valid), .ex_pc_o(d4_pc), .ex_rs1_data_o(d4_rs1_data),
        .ex_rs2_data_o(d4_rs2_data), .ex_imm_o(d4_imm), .ex_rs1_o(d4_rs1),
        .ex_rs2_o(d4_rs2), .ex_rd_o(d4_rd), .ex_ctrl_o(d4_ctrl), .ex_funct_o(d4_funct),
        .stall_o(d4_stall), .stall_cnt_o(d4_stall_cnt), .flush_cnt_o(d4_flush_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Expected EX contents and the number of bubbles of each kind so far.
    logic            m_valid;
    logic [XLEN-1:0] m_pc, m_rs1_data, m_rs2_data, m_imm;
    logic [4:0]      m_rs1, m_rs2, m_rd;
    logic [8:0]      m_ctrl;
    logic [9:0]      m_funct;
    int              m_nstall, m_nflush;

    task automatic model_reset();
        m_valid = 0; m_pc = '0; m_rs1_data = '0; m_rs2_data = '0; m_imm = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = '0; m_funct = '0;
        m_nstall = 0; m_nflush = 0;
    endtask

    // A valid load in EX writing a real register that ID (valid) reads.
    function automatic bit model_haz();
        return m_valid && m_ctrl[MEMREAD_BIT] && (m_rd != 0) && id_valid &&
               (m_rd == id_rs1 || m_rd == id_rs2);
    endfunction

    task automatic model_edge(input bit haz);
        if (hold) return;
        m_pc = id_pc; m_rs1_data = id_rs1_data; m_rs2_data = id_rs2_data;
        m_imm = id_imm; m_rs1 = id_rs1; m_rs2 = id_rs2; m_funct = id_funct;
        if (flush || haz) begin
            m_valid = 0; m_ctrl = '0; m_rd = '0;
            if (flush) m_nflush++;
            else       m_nstall++;
        end else begin
            m_valid = id_valid; m_ctrl = id_ctrl; m_rd = id_rd;
        end
    endtask

    function automatic logic [3:0] sat4(input int n);
        return (n > 15) ? 4'd15 : 4'(n);
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".ex_valid"},    ex_valid,    m_valid);
        check({tag, ".ex_pc"},       ex_pc,       m_pc);
        check({tag, ".ex_rs1_data"}, ex_rs1_data, m_rs1_data);
        check({tag, ".ex_rs2_data"}, ex_rs2_data, m_rs2_data);
        check({tag, ".ex_imm"},      ex_imm,      m_imm);
        check({tag, ".ex_rs1"},      ex_rs1,      m_rs1);
        check({tag, ".ex_rs2"},      ex_rs2,      m_rs2);
        check({tag, ".ex_rd"},       ex_rd,       m_rd);
        check({tag, ".ex_ctrl"},     ex_ctrl,     m_ctrl);
        check({tag, ".ex_funct"},    ex_funct,    m_funct);
        check({tag, ".stall_cnt"},   stall_cnt,   32'(m_nstall));
        check({tag, ".flush_cnt"},   flush_cnt,   32'(m_nflush));
        check({tag, ".d4_valid"},    d4_valid,    m_valid);
        check({tag, ".d4_stall_cnt"}, d4_stall_cnt, sat4(m_nstall));
        check({tag, ".d4_flush_cnt"}, d4_flush_cnt, sat4(m_nflush));
    endtask

    // Inputs are already driven; check stall mid-cycle, then the edge result.
    task automatic step(input string tag);
        bit h;
        @(negedge clk);
        h = model_haz();
        check({tag, ".stall"},    stall,    h & ~flush & ~hold);
        check({tag, ".d4_stall"}, d4_stall, h & ~flush & ~hold);
        model_edge(h);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit h, input bit f, input bit v, input bit [4:0] r1,
                         input bit [4:0] r2, input bit [4:0] d, input bit [8:0] c);
        hold = h; flush = f; id_valid = v;
        id_rs1 = r1; id_rs2 = r2; id_rd = d; id_ctrl = c;
        id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom;
        id_imm = $urandom; id_funct = 10'($urandom);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit       hold, flush, vld;
        bit [4:0] rs1, rs2, rd;
        bit [8:0] ctrl;
        bit       e_stall;
        bit       e_valid;
        bit [4:0] e_rd;
        bit [8:0] e_ctrl;
        int       e_scnt, e_fcnt;
    } vec_t;

    function automatic vec_t mk(bit h, bit f, bit v, bit [4:0] r1, bit [4:0] r2,
                                bit [4:0] d, bit [8:0] c, bit es, bit ev,
                                bit [4:0] erd, bit [8:0] ec, int sc, int fc);
        vec_t t;
        t.hold = h; t.flush = f; t.vld = v; t.rs1 = r1; t.rs2 = r2; t.rd = d;
        t.ctrl = c; t.e_stall = es; t.e_valid = ev; t.e_rd = erd; t.e_ctrl = ec;
        t.e_scnt = sc; t.e_fcnt = fc;
        return t;
    endfunction

    vec_t tbl[19];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        //          h f v rs1 rs2 rd  ctrl    stall valid rd ctrl   s f
        tbl[0]  = mk(0,0,1, 2, 0, 5, C_LW,   0, 1, 5, C_LW,   0,0); // lw x5
        tbl[1]  = mk(0,0,1, 5, 1, 6, C_ADD,  1, 0, 0, 9'h0,   1,0); // add x6,x5,x1 -> bubble
        tbl[2]  = mk(0,0,1, 5, 1, 6, C_ADD,  0, 1, 6, C_ADD,  1,0); // add loads
        tbl[3]  = mk(0,0,1, 3, 0, 0, C_LW,   0, 1, 0, C_LW,   1,0); // lw x0
        tbl[4]  = mk(0,0,1, 0, 0, 7, C_ADD,  0, 1, 7, C_ADD,  1,0); // reads x0: no stall
        tbl[5]  = mk(0,0,1, 1, 0, 5, C_ADDI, 0, 1, 5, C_ADDI, 1,0); // addi x5
        tbl[6]  = mk(0,0,1, 5, 5, 8, C_ADD,  0, 1, 8, C_ADD,  1,0); // non-load x5: no stall
        tbl[7]  = mk(0,0,1, 1, 0, 9, C_LW,   0, 1, 9, C_LW,   1,0); // lw x9
        tbl[8]  = mk(0,1,1, 1, 9,10, C_ADD,  0, 0, 0, 9'h0,   1,1); // flush beats hazard
        tbl[9]  = mk(0,0,1, 1, 0, 4, C_LW,   0, 1, 4, C_LW,   1,1); // lw x4
        tbl[10] = mk(1,0,1, 4, 0,11, C_ADD,  0, 1, 4, C_LW,   1,1); // hold over hazard
        tbl[11] = mk(1,0,1, 1, 4, 0, C_SW,   0, 1, 4, C_LW,   1,1); // hold
        tbl[12] = mk(1,1,1, 4, 0,11, C_ADD,  0, 1, 4, C_LW,   1,1); // hold beats flush
        tbl[13] = mk(0,0,1, 1, 4, 0, C_SW,   1, 0, 0, 9'h0,   2,1); // hazard re-evaluated
        tbl[14] = mk(0,0,1, 1, 4, 0, C_SW,   0, 1, 0, C_SW,   2,1); // sw loads
        tbl[15] = mk(0,0,0, 4, 0,12, C_LW,   0, 0,12, C_LW,   2,1); // invalid lw keeps ctrl
        tbl[16] = mk(0,0,1,12, 0,13, C_ADD,  0, 1,13, C_ADD,  2,1); // invalid load: no stall
        tbl[17] = mk(0,0,1, 1, 0,14, C_LW,   0, 1,14, C_LW,   2,1); // lw x14
        tbl[18] = mk(0,0,0,14, 0,15, C_ADD,  0, 0,15, C_ADD,  2,1); // invalid ID: no stall

        // Reset: asserted asynchronously, outputs clear without a clock edge.
        model_reset();
        #1 rst = 1'b1;
        #1;
        check_all("reset");
        check("reset.stall", stall, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_reset");

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].hold, tbl[i].flush, tbl[i].vld, tbl[i].rs1, tbl[i].rs2,
                  tbl[i].rd, tbl[i].ctrl);
            @(negedge clk);
            check($sformatf("tbl%0d.stall", i), stall, tbl[i].e_stall);
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d.valid", i), ex_valid, tbl[i].e_valid);
            check($sformatf("tbl%0d.rd", i), ex_rd, tbl[i].e_rd);
            check($sformatf("tbl%0d.ctrl", i), ex_ctrl, tbl[i].e_ctrl);
            check($sformatf("tbl%0d.stall_cnt", i), stall_cnt, 32'(tbl[i].e_scnt));
            check($sformatf("tbl%0d.flush_cnt", i), flush_cnt, 32'(tbl[i].e_fcnt));
            if (i == 2) check("tbl2.rs1_is_x5", ex_rs1, 5'd5);
        end

        // Re-align the model with the table run via one known load.
        model_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        check_all("realign_reset");
        drive(0, 0, 1, 1, 0, 5, C_LW);
        step("ar_ld");

        // Asynchronous reset mid-cycle with a hazard pending in ID.
        drive(0, 0, 1, 5, 1, 6, C_ADD);
        #1;
        check("ar.pre_stall", stall, 1'b1);
        rst = 1'b1;
        #1;
        model_reset();
        check_all("ar_mid");
        check("ar_mid.stall", stall, 1'b0);
        @(posedge clk);
        #1;
        check_all("ar_edge");
        #1 rst = 1'b0;
        step("ar_release");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 1) == 0) ? C_LW : 9'($urandom));
            step($sformatf("rnd%0d", i));
        end

        // Saturation: 17 load-use bubbles; the 4-bit counter stops at 15.
        rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 17; i++) begin
            drive(0, 0, 1, 2, 0, 5, C_LW);
            step($sformatf("sat%0d.ld", i));
            drive(0, 0, 1, 5, 1, 6, C_ADD);
            step($sformatf("sat%0d.use", i));
        end
        check("sat.d4_stall_cnt", d4_stall_cnt, 4'd15);
        check("sat.stall_cnt", stall_cnt, 32'd17);
        check("sat.d4_flush_cnt", d4_flush_cnt, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the five-stage core. Captures decoded operands, immediate, register indices and control from ID, and presents them to EX, the ALU operand muxes and the forwarding unit, which consumes `ex_rs1_o`, `ex_rs2_o` and downstream `rd`/`regwrite`. Inserts bubbles on load-use hazards and branch flushes, freezes on a global memory hold, and keeps saturating event counters for performance analysis.

## Interface
Parameters:
- `XLEN`, default 32: datapath width.
- `CNT_W`, default 32: stall/flush counter width.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `hold_i` in 1: global memory stall; freezes the stage.
- `flush_i` in 1: branch-taken flush of the instruction in ID.
- `id_valid_i` in 1: ID holds a real instruction.
- `id_pc_i` in XLEN: PC of the ID instruction.
- `id_rs1_data_i`, `id_rs2_data_i` in XLEN: register-file read data.
- `id_imm_i` in XLEN: sign-extended immediate.
- `id_rs1_i`, `id_rs2_i`, `id_rd_i` in 5: register indices.
- `id_ctrl_i` in 9: control bundle {regwrite, memtoreg, memread, memwrite, alusrc, aluop[1:0], branch, spare}.
- `id_funct_i` in 10: {funct7, funct3}.
- `ex_valid_o` out 1; `ex_pc_o`, `ex_rs1_data_o`, `ex_rs2_data_o`, `ex_imm_o` out XLEN; `ex_rs1_o`, `ex_rs2_o`, `ex_rd_o` out 5; `ex_ctrl_o` out 9; `ex_funct_o` out 10: registered EX-side copies.
- `stall_o` out 1: hold PC and IF/ID this cycle (combinational).
- `stall_cnt_o` out CNT_W: load-use bubbles inserted, saturating.
- `flush_cnt_o` out CNT_W: flush bubbles inserted, saturating.

## Operation
- Hazard: `haz = ex_ctrl_o.memread & ex_valid_o & (ex_rd_o != 0) & (ex_rd_o == id_rs1_i | ex_rd_o == id_rs2_i) & id_valid_i`.
- `stall_o = haz & ~flush_i & ~hold_i`.
- Per-edge action, priority order:
  - RESET (`rst_i`): all registers and counters to 0.
  - HOLD (`hold_i`): every register and counter keeps its value; flush/hazard ignored.
  - FLUSH (`flush_i`): bubble; `flush_cnt_o` += 1 (saturating).
  - STALL (`haz`): bubble; `stall_cnt_o` += 1 (saturating).
  - LOAD: all `ex_*` take `id_*`; `ex_valid_o <= id_valid_i`.
- Bubble: `ex_valid_o`, `ex_ctrl_o`, `ex_rd_o` are cleared to 0; PC, data, imm, rs1/rs2 and funct fields capture the ID values. Bubbles therefore never write and never trigger forwarding or hazards.
- `id_valid_i = 0` with no flush or hazard: a normal LOAD, which propagates `valid = 0` with the ID control unchanged. The downstream write gate uses `ex_valid_o`.
- Counters stop at all-ones and do not wrap.

## Timing
- Latency: 1 cycle from ID inputs to `ex_*` outputs.
- `stall_o` is combinational from current `ex_*` state and ID inputs. It is never asserted during reset, since all `ex_*` are 0.
- A load-use pair yields exactly one bubble. The edge after the hazard loads the bubble, `haz` drops, and the following edge loads the dependent instruction.
- Simultaneous flush and hazard: flush wins; `stall_o = 0`; only `flush_cnt_o` increments.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge. Release is synchronous to the next rising edge.
- Hold spanning a hazard: `stall_o` is 0 while held. The hazard re-evaluates once hold drops.

## Structure
- Shared package `pipe_pkg`:
  - struct `ctrl_t` (9-bit control bundle, field order above).
  - ALUOp constants `ALUOP_LDST`, `ALUOP_BR`, `ALUOP_R`, `ALUOP_I`.
  - `REG_ZERO = 5'd0`.
- Sub-module `hazard_detect` (combinational `haz` computation), instantiated once. The registers and counters live in `id_ex_stage`.

## Test plan
- Reset: assert `rst_i` asynchronously mid-cycle with the stage loaded → all outputs 0 before the next edge, `stall_o = 0`.
- Load-use: `lw x5` in EX, ID `add x6,x5,x1` → `stall_o = 1` for one cycle, `ex_ctrl_o = 0`, `ex_rd_o = 0`, `stall_cnt_o = 1`; the next edge loads the add with `ex_rs1_o = 5`.
- No false stall: `lw x0` in EX, ID reads x0 → `stall_o = 0`. Non-load writing x5 in EX → `stall_o = 0`.
- Flush over hazard: hazard present plus `flush_i = 1` → `stall_o = 0`, bubble loaded, `flush_cnt_o = 1`, `stall_cnt_o` unchanged.
- Hold: `hold_i = 1` for 3 cycles with changing ID inputs → `ex_*` and counters frozen, `stall_o = 0`. After release, the ID inputs load normally.
- Saturation: with `CNT_W = 4`, force 17 load-use bubbles → `stall_cnt_o` stops at 15.
